// File: rtl/rf_write_arbiter.sv
// ---------------------------------------------------------------------------
// rf_write_arbiter
//
// Purpose:
//   Shares the single register-file write port between two writeback sources.
//   Requester 0 is the ALU result path and requester 1 is the memory load
//   return path. A round-robin arbiter grants one requester per cycle. The
//   granted write goes through one registered stage and then drives the
//   reg_file wa/wr/wren pins. wren is an active-low strobe.
//   A saturating counter records how many cycles both requesters were valid
//   at the same time.
//
// Ports:
//   clk          - clock; all state changes on the rising edge
//   rstd         - asynchronous, active-high reset
//   req0_valid   - requester 0 has a write pending
//   req0_addr    - requester 0 destination register
//   req0_data    - requester 0 write data
//   req0_ready   - requester 0 granted this cycle (combinational)
//   req1_valid   - requester 1 has a write pending
//   req1_addr    - requester 1 destination register
//   req1_data    - requester 1 write data
//   req1_ready   - requester 1 granted this cycle (combinational)
//   rf_wa        - reg_file write address (registered)
//   rf_wr        - reg_file write data (registered)
//   rf_wren      - reg_file write strobe, active low (registered)
//   cnt_clr      - synchronous clear of conflict_cnt
//   conflict_cnt - saturating count of cycles in which both requesters were valid
// ---------------------------------------------------------------------------
module rf_write_arbiter #(
    parameter int AW           = 5,
    parameter int DW           = 32,
    parameter int CW           = 16,
    parameter bit ZERO_DISCARD = 1'b1
) (
    input  logic          clk,
    input  logic          rstd,
    input  logic          req0_valid,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_data,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_data,
    output logic          req1_ready,
    output logic [AW-1:0] rf_wa,
    output logic [DW-1:0] rf_wr,
    output logic          rf_wren,
    input  logic          cnt_clr,
    output logic [CW-1:0] conflict_cnt
);

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    // lastGrant_q holds the index of the most recent winner. It resets to 1
    // so that requester 0 wins the first conflict.
    logic          lastGrant_q, lastGrant_d;
    logic [AW-1:0] rfWa_q,      rfWa_d;
    logic [DW-1:0] rfWr_q,      rfWr_d;
    logic          rfWren_q,    rfWren_d;
    logic [CW-1:0] conflictCnt_q, conflictCnt_d;

    logic          grant0;
    logic          grant1;
    logic          transfer;
    logic [AW-1:0] selAddr;
    logic [DW-1:0] selData;
    logic          discard;

    // Round-robin grant. A lone valid requester always wins. When both are
    // valid, the requester that did not win last time gets the grant. Ready
    // depends only on the valids and the pointer, never on the output stage.
    always_comb begin
        grant0 = req0_valid & (~req1_valid | lastGrant_q);
        grant1 = req1_valid & (~req0_valid | ~lastGrant_q);
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign transfer   = grant0 | grant1;

    // Steer the winning requester's address and data into the output stage.
    // A write to register 0 is still accepted when discard is enabled, but
    // it never reaches the port.
    always_comb begin
        selAddr = grant1 ? req1_addr : req0_addr;
        selData = grant1 ? req1_data : req0_data;
        discard = ZERO_DISCARD && (selAddr == '0);
    end

    // Next-state logic. The strobe is active for one cycle per accepted,
    // non-discarded write, so back-to-back transfers keep it low. Address and
    // data keep their previous values when no write is issued.
    always_comb begin
        lastGrant_d   = lastGrant_q;
        rfWa_d        = rfWa_q;
        rfWr_d        = rfWr_q;
        rfWren_d      = 1'b1;
        conflictCnt_d = conflictCnt_q;

        if (transfer) begin
            lastGrant_d = grant1;
            if (!discard) begin
                rfWa_d   = selAddr;
                rfWr_d   = selData;
                rfWren_d = 1'b0;
            end
        end

        // A clear takes priority over a conflict increment. The counter
        // holds at its maximum value instead of wrapping.
        if (cnt_clr) begin
            conflictCnt_d = '0;
        end else if (req0_valid && req1_valid && (conflictCnt_q != CNT_MAX)) begin
            conflictCnt_d = conflictCnt_q + 1'b1;
        end
    end

    // State registers. Reset drops any write that is in flight.
    always_ff @(posedge clk or posedge rstd) begin
        if (rstd) begin
            lastGrant_q   <= 1'b1;
            rfWa_q        <= '0;
            rfWr_q        <= '0;
            rfWren_q      <= 1'b1;
            conflictCnt_q <= '0;
        end else begin
            lastGrant_q   <= lastGrant_d;
            rfWa_q        <= rfWa_d;
            rfWr_q        <= rfWr_d;
            rfWren_q      <= rfWren_d;
            conflictCnt_q <= conflictCnt_d;
        end
    end

    assign rf_wa        = rfWa_q;
    assign rf_wr        = rfWr_q;
    assign rf_wren      = rfWren_q;
    assign conflict_cnt = conflictCnt_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rf_write_arbiter
//
// Purpose:
//   Self-checking bench for rf_write_arbiter. It uses a 4-bit conflict
//   counter and keeps register-0 discard enabled. Random requesters are
//   driven against a reference model. Each expected port write is queued,
//   and a separate monitor pops and compares every cycle.
// Ports: none (top-level bench)
// ---------------------------------------------------------------------------
module tb_rf_write_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int CW = 4;
    localparam int CNT_SAT = (1 << CW) - 1;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wrExp_t;

    logic          clk = 1'b0;
    logic          rstd;
    logic          req0_valid, req1_valid;
    logic [AW-1:0] req0_addr,  req1_addr;
    logic [DW-1:0] req0_data,  req1_data;
    logic          req0_ready, req1_ready;
    logic [AW-1:0] rf_wa;
    logic [DW-1:0] rf_wr;
    logic          rf_wren;
    logic          cnt_clr;
    logic [CW-1:0] conflict_cnt;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state.
    wrExp_t        expQ[$];
    int            lastWinner;
    int            expCnt;
    logic [AW-1:0] heldAddr;
    logic [DW-1:0] heldData;
    bit            pend[2];
    logic [AW-1:0] pAddr[2];
    logic [DW-1:0] pData[2];
    bit            monOn = 1'b0;

    rf_write_arbiter #(.AW(AW), .DW(DW), .CW(CW), .ZERO_DISCARD(1'b1)) dut (
        .clk          (clk),
        .rstd         (rstd),
        .req0_valid   (req0_valid),
        .req0_addr    (req0_addr),
        .req0_data    (req0_data),
        .req0_ready   (req0_ready),
        .req1_valid   (req1_valid),
        .req1_addr    (req1_addr),
        .req1_data    (req1_data),
        .req1_ready   (req1_ready),
        .rf_wa        (rf_wa),
        .rf_wr        (rf_wr),
        .rf_wren      (rf_wren),
        .cnt_clr      (cnt_clr),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    // Single point of comparison; every check funnels through here.
    task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                               input logic [DW-1:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of requester activity just after the rising edge, then
    // judge the grant at the falling edge and record the expected outcome.
    task automatic applyStimulus(input int validPct, input bit forceBoth, input int clrPct);
        int winner;
        @(posedge clk);
        #1;
        for (int r = 0; r < 2; r++) begin
            if (!pend[r] && (forceBoth || ($urandom_range(99) < validPct))) begin
                pend[r]  = 1'b1;
                pAddr[r] = AW'($urandom_range(7));
                pData[r] = $urandom;
            end
        end
        req0_valid = pend[0]; req0_addr = pAddr[0]; req0_data = pData[0];
        req1_valid = pend[1]; req1_addr = pAddr[1]; req1_data = pData[1];
        cnt_clr    = ($urandom_range(99) < clrPct);

        @(negedge clk);
        // Fair sharing: a lone requester wins; on a tie the one that did not
        // win most recently goes first.
        if (pend[0] && pend[1])  winner = 1 - lastWinner;
        else if (pend[0])        winner = 0;
        else if (pend[1])        winner = 1;
        else                     winner = -1;
        checkOutput("req0_ready", {31'b0, req0_ready}, {31'b0, winner == 0});
        checkOutput("req1_ready", {31'b0, req1_ready}, {31'b0, winner == 1});
        if (winner >= 0) begin
            if (pAddr[winner] != 0) expQ.push_back('{addr: pAddr[winner], data: pData[winner]});
            pend[winner] = 1'b0;
            lastWinner   = winner;
        end
        if (cnt_clr)                     expCnt = 0;
        else if (pend[0] || winner == 0)
            if ((req0_valid && req1_valid) && expCnt < CNT_SAT) expCnt = expCnt + 1;
    endtask

    // Monitor: shortly after each rising edge, compare the port against the
    // oldest expected write, or against the held values if none is due.
    initial begin
        wrExp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (monOn) begin
                if (expQ.size() > 0) begin
                    e = expQ.pop_front();
                    checkOutput("rf_wren_active", {31'b0, rf_wren}, 32'd0);
                    checkOutput("rf_wa", {27'b0, rf_wa}, {27'b0, e.addr});
                    checkOutput("rf_wr", rf_wr, e.data);
                    heldAddr = e.addr;
                    heldData = e.data;
                end else begin
                    checkOutput("rf_wren_idle", {31'b0, rf_wren}, 32'd1);
                    checkOutput("rf_wa_held", {27'b0, rf_wa}, {27'b0, heldAddr});
                    checkOutput("rf_wr_held", rf_wr, heldData);
                end
                checkOutput("conflict_cnt", {28'b0, conflict_cnt}, expCnt[DW-1:0]);
            end
        end
    end

    initial begin
        rstd = 1'b1;
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
        cnt_clr = 1'b0;
        pend[0] = 1'b0; pend[1] = 1'b0;
        pAddr[0] = '0; pAddr[1] = '0; pData[0] = '0; pData[1] = '0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_wren", {31'b0, rf_wren}, 32'd1);
        checkOutput("reset_wa", {27'b0, rf_wa}, 32'd0);
        checkOutput("reset_wr", rf_wr, 32'd0);
        checkOutput("reset_cnt", {28'b0, conflict_cnt}, 32'd0);
        @(negedge clk);
        rstd = 1'b0;

        // First conflict after reset goes to requester 0; the write then sits
        // on the port when reset hits asynchronously.
        @(posedge clk);
        #1;
        req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'haaaaaaaa;
        req1_valid = 1'b1; req1_addr = 5'd5; req1_data = 32'h12345678;
        @(negedge clk);
        checkOutput("first_conflict_r0", {31'b0, req0_ready}, 32'd1);
        checkOutput("first_conflict_r1", {31'b0, req1_ready}, 32'd0);
        @(posedge clk);
        #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        checkOutput("write_wren", {31'b0, rf_wren}, 32'd0);
        checkOutput("write_wa", {27'b0, rf_wa}, 32'd3);
        checkOutput("write_wr", rf_wr, 32'haaaaaaaa);
        checkOutput("write_cnt", {28'b0, conflict_cnt}, 32'd1);
        #1;
        rstd = 1'b1;
        #1;
        checkOutput("async_rst_wren", {31'b0, rf_wren}, 32'd1);
        checkOutput("async_rst_wa", {27'b0, rf_wa}, 32'd0);
        checkOutput("async_rst_cnt", {28'b0, conflict_cnt}, 32'd0);
        @(negedge clk);
        rstd = 1'b0;

        lastWinner = 1;
        expCnt     = 0;
        heldAddr   = '0;
        heldData   = '0;
        expQ.delete();
        monOn = 1'b1;

        // Mixed random traffic with occasional clears.
        for (int i = 0; i < 300; i++) applyStimulus(50, 1'b0, 5);
        // Both requesters saturated: alternating grants, counter pins at max.
        for (int i = 0; i < 25; i++) applyStimulus(100, 1'b1, 0);
        // Clear while both are still valid, then let the count resume.
        applyStimulus(100, 1'b1, 100);
        for (int i = 0; i < 3; i++) applyStimulus(100, 1'b1, 0);
        // Sparse traffic exposes idle gaps between writes.
        for (int i = 0; i < 150; i++) applyStimulus(20, 1'b0, 3);
        // Drain all outstanding requests.
        for (int i = 0; i < 6; i++) applyStimulus(0, 1'b0, 0);
        @(posedge clk);
        #3;
        monOn = 1'b0;
        checkOutput("queue_drained", expQ.size(), 32'd0);
        checkOutput("requests_drained", {30'b0, pend[1], pend[0]}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
